// File: rtl/amfm_pkg.sv
// Shared types and constants for the AM/FM modulator core.
// Includes the rounded sine-table entry used by amfm_sine_lut.
package amfm_pkg;

  typedef enum logic [1:0] {
    MUTE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } amfm_state_e;

  localparam logic MODE_AM  = 1'b0;
  localparam logic MODE_FM  = 1'b1;
  localparam int   PIPE_LAT = 4;

  localparam real PI = 3.14159265358979323846;

  // amp*sin(2*pi*idx/n), rounded half away from zero so the table is odd-symmetric
  function automatic int sine_round(input int idx, input int n, input int amp);
    real x;
    x = real'(amp) * $sin(2.0 * PI * real'(idx) / real'(n));
    if (x >= 0.0) begin
      return $rtoi(x + 0.5);
    end else begin
      return -$rtoi(-x + 0.5);
    end
  endfunction

endpackage

// File: rtl/amfm_sine_lut.sv
// Registered sine table, one cycle read latency.
// AMFM_QUARTER_LUT_EN selects a folded quarter-wave table with identical output.
module amfm_sine_lut
  import amfm_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int LUT_AW = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LUT_AW-1:0]        addr_i,
  output logic signed [DATA_W-1:0] data_o
);

  localparam int N   = 2 ** LUT_AW;
  localparam int AMP = 2 ** (DATA_W - 1) - 1;

  logic signed [DATA_W-1:0] data_d;
  logic signed [DATA_W-1:0] data_q;

`ifdef AMFM_QUARTER_LUT_EN
  localparam int QN = N / 4;

  logic signed [DATA_W-1:0] rom_s [QN+1];
  logic [LUT_AW-2:0]        idx_s;

  for (genvar g = 0; g <= QN; g++) begin : g_rom
    assign rom_s[g] = DATA_W'(sine_round(g, N, AMP));
  end

  // Second and fourth quadrants mirror the index, the lower half-wave negates.
  always_comb begin
    if (addr_i[LUT_AW-2]) begin
      idx_s = (LUT_AW-1)'(QN) - {1'b0, addr_i[LUT_AW-3:0]};
    end else begin
      idx_s = {1'b0, addr_i[LUT_AW-3:0]};
    end
    if (addr_i[LUT_AW-1]) begin
      data_d = -rom_s[idx_s];
    end else begin
      data_d = rom_s[idx_s];
    end
  end
`else
  logic signed [DATA_W-1:0] rom_s [N];

  for (genvar g = 0; g < N; g++) begin : g_rom
    assign rom_s[g] = DATA_W'(sine_round(g, N, AMP));
  end

  always_comb begin
    data_d = rom_s[addr_i];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/amfm_mod_core.sv
// AM/FM modulator: DDS carrier on one of CH_NUM channels, muted re-configuration.
// Optional macro AMFM_QUARTER_LUT_EN selects the quarter-wave sine table.
module amfm_mod_core
  import amfm_pkg::*;
#(
  parameter int DATA_W   = 10,
  parameter int MSG_W    = 8,
  parameter int PHASE_W  = 32,
  parameter int LUT_AW   = 10,
  parameter int CH_NUM   = 3,
  parameter int MUTE_CYC = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic                       ch_next,
  input  logic [PHASE_W-1:0]         base_fcw,
  input  logic [PHASE_W-1:0]         step_fcw,
  input  logic [15:0]                fm_dev_k,
  input  logic [7:0]                 am_depth,
  input  logic [MSG_W-1:0]           msg_data,
  input  logic                       msg_valid,
  output logic [DATA_W-1:0]          dac_data,
  output logic                       dac_valid,
  output logic [$clog2(CH_NUM)-1:0]  ch_idx,
  output logic                       mode_active
);

  localparam int CH_W  = $clog2(CH_NUM);
  localparam int CNT_W = $clog2(MUTE_CYC + 1);
  localparam int AMP_W = MSG_W + 9;
  localparam int AMO_W = DATA_W + MSG_W + 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MUTE_CYC - 1);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(CH_NUM - 1);
  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [MSG_W-1:0]  ENV_MID  = {1'b1, {(MSG_W-1){1'b0}}};

  amfm_state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              mode_act_q, mode_act_d;
  logic              pend_q, pend_d;
  logic              v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [DATA_W-1:0] dac_q, dac_d;
  logic              dac_valid_q, dac_valid_d;
  logic              run_next_s;

  logic [MSG_W-1:0]   msg_q, msg_eff_s;
  logic [PHASE_W-1:0] fc_s, fm_term_s, fcw_d, fcw_q, phase_d, phase_q;
  logic [AMP_W-1:0]   am_prod_s;
  logic [MSG_W-1:0]   env_d, env1_q, env2_q, env3_q;
  logic signed [DATA_W-1:0] sine_s;
  logic [AMO_W-1:0]   am_out_s;
  logic [DATA_W-1:0]  samp_s;
  logic               unused_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MUTE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MUTE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = LOAD;
        end else begin
          state_d = MUTE;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (ch_next || (mode != mode_act_q)) begin
          state_d = MUTE;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = MUTE;
    endcase
  end

  // Output and control next-values; anything not heading into RUN is flushed to midscale.
  always_comb begin
    run_next_s  = (state_d == RUN);
    cnt_d       = '0;
    ch_d        = ch_q;
    mode_act_d  = mode_act_q;
    pend_d      = pend_q | ch_next;
    if ((state_q == MUTE) && (state_d == MUTE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
    if (state_q == LOAD) begin
      pend_d     = 1'b0;
      mode_act_d = mode;
      if (pend_q || ch_next) begin
        if (ch_q == CH_LAST) begin
          ch_d = '0;
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end else begin
        ch_d = ch_q;
      end
    end else begin
      mode_act_d = mode_act_q;
    end
    v1_d        = (state_q == RUN) && run_next_s;
    v2_d        = v1_q && run_next_s;
    v3_d        = v2_q && run_next_s;
    dac_valid_d = v3_q && run_next_s;
    if (!dac_valid_d) begin
      dac_d = MIDSCALE;
    end else if (mode_act_q == MODE_FM) begin
      dac_d = {~sine_s[DATA_W-1], sine_s[DATA_W-2:0]};
    end else begin
      dac_d = {~samp_s[DATA_W-1], samp_s[DATA_W-2:0]};
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      ch_q        <= '0;
      mode_act_q  <= MODE_AM;
      pend_q      <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      dac_q       <= MIDSCALE;
      dac_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      mode_act_q  <= mode_act_d;
      pend_q      <= pend_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      dac_q       <= dac_d;
      dac_valid_q <= dac_valid_d;
    end
  end

  // A sample strobed this cycle enters P1 directly, giving the 4-cycle message latency.
  assign msg_eff_s = msg_valid ? msg_data : msg_q;

  assign fc_s      = base_fcw + ({{(PHASE_W-CH_W){1'b0}}, ch_q} * step_fcw);
  assign fm_term_s = {{(PHASE_W-MSG_W){msg_eff_s[MSG_W-1]}}, msg_eff_s} *
                     {{(PHASE_W-16){1'b0}}, fm_dev_k};
  assign am_prod_s = {{(AMP_W-MSG_W){msg_eff_s[MSG_W-1]}}, msg_eff_s} *
                     {{(AMP_W-8){1'b0}}, am_depth};
  assign env_d     = am_prod_s[MSG_W+7:8] + ENV_MID;

  // P1 frequency word and phase accumulator; LOAD restarts the phase at zero.
  always_comb begin
    if (mode_act_q == MODE_FM) begin
      fcw_d = fc_s + fm_term_s;
    end else begin
      fcw_d = fc_s;
    end
    if (state_q == LOAD) begin
      phase_d = '0;
    end else if (v1_q) begin
      phase_d = phase_q + fcw_q;
    end else begin
      phase_d = phase_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_q   <= '0;
      fcw_q   <= '0;
      phase_q <= '0;
      env1_q  <= '0;
      env2_q  <= '0;
      env3_q  <= '0;
    end else begin
      msg_q   <= msg_eff_s;
      fcw_q   <= fcw_d;
      phase_q <= phase_d;
      env1_q  <= env_d;
      env2_q  <= env1_q;
      env3_q  <= env2_q;
    end
  end

  amfm_sine_lut #(
    .DATA_W (DATA_W),
    .LUT_AW (LUT_AW)
  ) u_lut (
    .clk    (clk),
    .rst    (rst),
    .addr_i (phase_q[PHASE_W-1 -: LUT_AW]),
    .data_o (sine_s)
  );

  // AM scaling: (sine * env) >>> MSG_W, envelope delayed to line up with the LUT output.
  assign am_out_s = {{(AMO_W-DATA_W){sine_s[DATA_W-1]}}, sine_s} *
                    {{(AMO_W-MSG_W){1'b0}}, env3_q};
  assign samp_s   = am_out_s[DATA_W+MSG_W-1:MSG_W];

  assign unused_s = ^{am_prod_s[AMP_W-1:MSG_W+8], am_prod_s[7:0],
                      am_out_s[AMO_W-1:DATA_W+MSG_W], am_out_s[MSG_W-1:0]};

  assign dac_data    = dac_q;
  assign dac_valid   = dac_valid_q;
  assign ch_idx      = ch_q;
  assign mode_active = mode_act_q;

endmodule

// File: tb/tb_amfm_mod_core.sv
// Directed self-checking bench for amfm_mod_core with hand-computed DAC words.
module tb_amfm_mod_core;

  logic        clk;
  logic        rst;
  logic        mode;
  logic        ch_next;
  logic [31:0] base_fcw;
  logic [31:0] step_fcw;
  logic [15:0] fm_dev_k;
  logic [7:0]  am_depth;
  logic [7:0]  msg_data;
  logic        msg_valid;
  logic [9:0]  dac_data;
  logic        dac_valid;
  logic [1:0]  ch_idx;
  logic        mode_active;

  int n_tests = 0;
  int n_fail  = 0;
  int k;

  // 511*sin(2*pi*k/16) + 512, and AM at depth 255 / msg 0: floor(sine/2) + 512
  int fm_tab [16] = '{512, 708, 873, 984, 1023, 984, 873, 708, 512, 316, 151, 40, 1, 40, 151, 316};
  int am_tab [16] = '{512, 610, 692, 748, 767, 748, 692, 610, 512, 414, 331, 276, 256, 276, 331, 414};
  // after msg -> -128 with fm_dev_k=390: LUT indices 63,127,191,255
  int fm_dev_tab [4] = '{705, 871, 983, 1023};
  // first sample after a channel reload (FM, msg 0): channel 1,2,0
  int ch_first [3] = '{753, 796, 708};

  amfm_mod_core dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .ch_next     (ch_next),
    .base_fcw    (base_fcw),
    .step_fcw    (step_fcw),
    .fm_dev_k    (fm_dev_k),
    .am_depth    (am_depth),
    .msg_data    (msg_data),
    .msg_valid   (msg_valid),
    .dac_data    (dac_data),
    .dac_valid   (dac_valid),
    .ch_idx      (ch_idx),
    .mode_active (mode_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts non-valid cycles from the current one; optional ch_next pulses at given offsets.
  task automatic wait_valid(input string tag, input int exp_low, input int pa, input int pb);
    int lowcnt;
    int bad;
    lowcnt = 0;
    bad    = 0;
    while (!dac_valid && lowcnt < 400) begin
      if (dac_data != 10'd512) bad++;
      ch_next = (lowcnt == pa) || (lowcnt == pb);
      lowcnt++;
      tick();
    end
    ch_next = 1'b0;
    check_eq({tag, "_low_cycles"}, lowcnt, exp_low);
    check_eq({tag, "_midscale"}, bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    ch_next   = 1'b0;
    base_fcw  = 32'h1000_0000;
    step_fcw  = 32'h0400_0000;
    fm_dev_k  = 16'd390;
    am_depth  = 8'd255;
    msg_data  = 8'd0;
    msg_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state, then AM start-up
    check_eq("rst_dac", dac_data, 512);
    check_eq("rst_valid", dac_valid, 0);
    check_eq("rst_ch", ch_idx, 0);
    check_eq("rst_mode", mode_active, 0);
    wait_valid("am_start", 69, -1, -1);
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("am_k%0d", (i + 1) % 16), dac_data, am_tab[(i + 1) % 16]);
      tick();
    end

    // switch to FM
    mode = 1'b1;
    tick();
    wait_valid("to_fm", 69, -1, -1);
    check_eq("fm_mode_active", mode_active, 1);
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("fm_k%0d", (i + 1) % 16), dac_data, fm_tab[(i + 1) % 16]);
      tick();
    end

    // message step to -128 at cycle n, where the n+4 sample is nominal k=1
    k = 1;
    while (k != 13) begin
      tick();
      k = (k + 1) % 16;
    end
    check_eq("dev_n", dac_data, fm_tab[13]);
    msg_data  = 8'h80;
    msg_valid = 1'b1;
    tick();
    msg_valid = 1'b0;
    check_eq("dev_n1", dac_data, fm_tab[14]);
    tick();
    check_eq("dev_n2", dac_data, fm_tab[15]);
    tick();
    check_eq("dev_n3", dac_data, fm_tab[0]);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("dev_n%0d", i + 4), dac_data, fm_dev_tab[i]);
    end
    msg_data  = 8'd0;
    msg_valid = 1'b1;
    tick();
    msg_valid = 1'b0;

    // three channel advances
    for (int i = 0; i < 3; i++) begin
      ch_next = 1'b1;
      tick();
      ch_next = 1'b0;
      wait_valid($sformatf("ch_adv%0d", i), 69, -1, -1);
      check_eq($sformatf("ch_adv%0d_idx", i), ch_idx, (i + 1) % 3);
      check_eq($sformatf("ch_adv%0d_first", i), dac_data, ch_first[i]);
    end
    tick();
    check_eq("ch0_second", dac_data, fm_tab[2]);

    // channel + mode change together, extra pulses during MUTE collapse
    mode    = 1'b0;
    ch_next = 1'b1;
    tick();
    ch_next = 1'b0;
    wait_valid("both", 69, 3, 40);
    check_eq("both_ch", ch_idx, 1);
    check_eq("both_mode", mode_active, 0);
    check_eq("both_first_am", dac_data, 632);

    // to channel 2 FM, then asynchronous reset mid-RUN
    mode    = 1'b1;
    ch_next = 1'b1;
    tick();
    ch_next = 1'b0;
    wait_valid("ch2fm", 69, -1, -1);
    check_eq("ch2fm_idx", ch_idx, 2);
    check_eq("ch2fm_mode", mode_active, 1);
    check_eq("ch2fm_first", dac_data, ch_first[1]);
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_dac", dac_data, 512);
    check_eq("arst_valid", dac_valid, 0);
    check_eq("arst_ch", ch_idx, 0);
    check_eq("arst_mode", mode_active, 0);
    mode = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_eq("post_rst_dac", dac_data, 512);
    check_eq("post_rst_valid", dac_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
